// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the MULT/MULTU/DIV/DIVU sequencer: op encodings,
// FSM state type and the divide-by-zero LO pattern.
package muldiv_sequencer_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX_A,
        ST_FIX_B
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_v);
        return op_v[0];
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple adder with a fixed carry-in; the sequencer builds both its
// add and subtract datapaths from two of these.
module adder_32bit #(
    parameter bit CARRY_IN_0 = 1'b0
) (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, CARRY_IN_0};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS HI/LO unit: shift-add multiply and restoring divide over
// ITER iterations, sharing one add adder and one subtract adder.
//
// state    | meaning
// IDLE     | waiting for start; MTHI/MTLO writes accepted
// PREP     | take operand magnitudes, trap divide by zero
// RUN      | one multiply/divide iteration per cycle
// FIX_A    | signed result sign fix (product, or quotient)
// FIX_B    | signed divide remainder sign fix
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;

    logic [31:0] add_a, add_b, add_sum;
    logic [31:0] sub_a, sub_b, sub_sum;
    logic        add_cout, sub_cout;
    logic [31:0] r_sh;
    logic        m_bit;
    logic [31:0] run_hi_d, run_lo_d;
    logic [31:0] a_mag, b_mag;
    logic        sgn_diff;

    adder_32bit #(.CARRY_IN_0(1'b0)) u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    adder_32bit #(.CARRY_IN_0(1'b1)) u_sub (
        .a_i    (sub_a),
        .b_i    (~sub_b),
        .sum_o  (sub_sum),
        .cout_o (sub_cout)
    );

    assign r_sh     = {acc_hi_q[30:0], acc_lo_q[31]};
    assign m_bit    = acc_hi_q[31];
    assign sgn_diff = neg_a_q ^ neg_b_q;
    assign a_mag    = neg_a_q ? sub_sum : a_q;
    assign b_mag    = neg_b_q ? add_sum : b_q;

    // Both adders are time-shared; operands depend only on the current state.
    always_comb begin
        add_a = '0;
        add_b = '0;
        sub_a = '0;
        sub_b = '0;
        case (state_q)
            ST_PREP: begin
                sub_b = a_q;
                add_a = ~b_q;
                add_b = 32'd1;
            end
            ST_RUN: begin
                if (op_is_div(op_q)) begin
                    sub_a = r_sh;
                    sub_b = b_q;
                end else begin
                    add_a = acc_hi_q;
                    add_b = a_q;
                end
            end
            ST_FIX_A: begin
                sub_b = acc_lo_q;
                add_a = ~acc_hi_q;
                add_b = {31'd0, (acc_lo_q == 32'd0)};
            end
            ST_FIX_B: begin
                sub_b = acc_hi_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        run_hi_d = '0;
        run_lo_d = '0;
        if (op_is_div(op_q)) begin
            if (m_bit || sub_cout) begin
                run_hi_d = sub_sum;
                run_lo_d = {acc_lo_q[30:0], 1'b1};
            end else begin
                run_hi_d = r_sh;
                run_lo_d = {acc_lo_q[30:0], 1'b0};
            end
        end else if (acc_lo_q[0]) begin
            run_hi_d = {add_cout, add_sum[31:1]};
            run_lo_d = {add_sum[0], acc_lo_q[31:1]};
        end else begin
            run_hi_d = {1'b0, acc_hi_q[31:1]};
            run_lo_d = {acc_hi_q[0], acc_lo_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULTU;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= rs_val;
                        b_q     <= rt_val;
                        neg_a_q <= op_is_signed(op) & rs_val[31];
                        neg_b_q <= op_is_signed(op) & rt_val[31];
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                ST_PREP: begin
                    if (op_is_div(op_q) && (b_q == 32'd0)) begin
                        hi_q    <= a_q;
                        lo_q    <= DIV0_LO;
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        a_q      <= a_mag;
                        b_q      <= b_mag;
                        acc_hi_q <= '0;
                        acc_lo_q <= op_is_div(op_q) ? a_mag : b_mag;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_hi_q <= run_hi_d;
                    acc_lo_q <= run_lo_d;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        if (op_is_signed(op_q)) begin
                            state_q <= ST_FIX_A;
                        end else begin
                            hi_q    <= run_hi_d;
                            lo_q    <= run_lo_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FIX_A: begin
                    if (op_is_div(op_q)) begin
                        if (sgn_diff) acc_lo_q <= sub_sum;
                        state_q <= ST_FIX_B;
                    end else begin
                        hi_q    <= sgn_diff ? add_sum : acc_hi_q;
                        lo_q    <= sgn_diff ? sub_sum : acc_lo_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FIX_B: begin
                    // Remainder takes the dividend's sign.
                    hi_q    <= neg_a_q ? sub_sum : acc_hi_q;
                    lo_q    <= acc_lo_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
